// File: rtl/sram_write_front_pkg.sv
// Shared definitions for the SRAM write front end.
//   - width encodings for the shifter conf field
//   - control FSM state enum
//   - mask_for(): byte-lane enables for a narrow write
package sram_write_front_pkg;

    localparam logic [1:0] CONF_32   = 2'b00;
    localparam logic [1:0] CONF_16   = 2'b01;
    localparam logic [1:0] CONF_8    = 2'b10;
    localparam logic [1:0] CONF_RSVD = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_t;

    // Byte enables for a write of width 'conf' at byte offset 'addr_lo'.
    // 16-bit writes are halfword aligned, so addr_lo[0] is ignored.
    function automatic logic [3:0] mask_for(input logic [1:0] conf,
                                            input logic [1:0] addr_lo);
        logic [3:0] m;
        case (conf)
            CONF_32: m = 4'b1111;
            CONF_16: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            CONF_8:  m = 4'b0001 << addr_lo;
            default: m = 4'b1111;   // reserved never reaches the conf register
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// Small synchronous FIFO holding queued SRAM write requests.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (flushes contents)
//   push, din    write an entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   dout         head entry, combinational
//   full, empty  occupancy flags
module sram_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_write_front.sv
// Write-request front end for the configurable-width SRAM.
// Queues narrow byte-addressed writes, derives word address and byte mask
// at accept time, and drives the head entry to the SRAM / input shifter.
// Owns the width register: a width change first drains every queued write
// so conf never moves under a pending write.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/ready, req_addr/data write request handshake
//   cfg_valid/ready, cfg_conf      width change request (ready = 1-cycle pulse)
//   cfg_err                        sticky, reserved width requested
//   sram_stall                     SRAM cannot take a write this cycle
//   we, waddr, wmask, D            head write towards SRAM / shifter
//   conf                           registered width to the shifter
module sram_write_front
    import sram_write_front_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_data,
    input  logic          cfg_valid,
    input  logic [1:0]    cfg_conf,
    output logic          cfg_ready,
    output logic          cfg_err,
    input  logic          sram_stall,
    output logic          we,
    output logic [AW-3:0] waddr,
    output logic [3:0]    wmask,
    output logic [31:0]   D,
    output logic [1:0]    conf
);
    typedef struct packed {
        logic [AW-3:0] waddr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } wreq_t;

    state_t     state, state_nx;
    logic [1:0] cfg_lat;
    logic       full, empty, push;
    wreq_t      push_ent, head;

    assign push_ent.waddr = req_addr[AW-1:2];
    assign push_ent.data  = req_data;
    assign push_ent.mask  = mask_for(conf, req_addr[1:0]);

    assign push = req_valid && req_ready;
    assign we   = !empty && !sram_stall;

    sram_req_fifo #(.DEPTH(DEPTH), .W($bits(wreq_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_ent),
        .pop   (we),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign waddr = head.waddr;
    assign wmask = head.mask;
    assign D     = head.data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            cfg_lat <= CONF_32;
            conf    <= CONF_32;
            cfg_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == RUN && cfg_valid) cfg_lat <= cfg_conf;
            if (state == APPLY) begin
                if (cfg_lat == CONF_RSVD) cfg_err <= 1'b1;
                else                      conf    <= cfg_lat;
            end
        end
    end

    // Config has priority over a same-cycle request, and a full FIFO
    // blocks accept even if the head pops this cycle.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        cfg_ready = 1'b0;
        case (state)
            RUN: begin
                req_ready = !full && !cfg_valid;
                if (cfg_valid) state_nx = DRAIN;
            end
            DRAIN: begin
                if (empty) state_nx = APPLY;
            end
            APPLY: begin
                cfg_ready = 1'b1;
                state_nx  = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

endmodule
